// File: rtl/rocket_pkg.sv
// Shared definitions for the voice allocator: allocator FSM encodings and the
// default widths and voice count used by the CPU register map and the bench.
package rocket_pkg;

  localparam int VOICES_DEFAULT = 4;
  localparam int FREQ_BITS      = 32;
  localparam int NOTE_BITS      = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RETRIG = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/voice_lru.sv
// Least-recently-used rank tracker for the oscillator voices. Rank 0 is the
// most recently assigned voice and rank VOICES-1 the oldest. The ranks always
// form a permutation of 0..VOICES-1.
module voice_lru #(
  parameter int VOICES    = 4,
  parameter int RANK_BITS = $clog2(VOICES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 touch,
  input  logic [RANK_BITS-1:0] touch_idx,
  output logic [RANK_BITS-1:0] rank [VOICES],
  output logic [RANK_BITS-1:0] oldest
);

  localparam logic [RANK_BITS-1:0] MAX_RANK = RANK_BITS'(VOICES - 1);

  logic [RANK_BITS-1:0] touched_rank;

  assign touched_rank = rank[touch_idx];

  // A touch makes one voice the newest and ages every voice that was newer than it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        rank[i] <= RANK_BITS'(VOICES - 1 - i);
      end
    end else if (touch) begin
      for (int i = 0; i < VOICES; i++) begin
        if (RANK_BITS'(i) == touch_idx) begin
          rank[i] <= '0;
        end else if (rank[i] < touched_rank) begin
          rank[i] <= rank[i] + 1'b1;
        end
      end
    end
  end

  // The oldest voice is the one holding the top rank, lowest index on a tie
  always_comb begin
    oldest = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (rank[i] == MAX_RANK) begin
        oldest = RANK_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Each accepted note event is checked against the
// voices one per cycle, then committed: same-note retrigger first, then the
// least-recently-used free voice, then the oldest voice is stolen. Retriggered
// or stolen voices have their gate held low for RETRIG_CYCLES so the envelope
// restarts cleanly.
module voice_allocator #(
  parameter int VOICES        = rocket_pkg::VOICES_DEFAULT,
  parameter int FREQ_BITS     = rocket_pkg::FREQ_BITS,
  parameter int NOTE_BITS     = rocket_pkg::NOTE_BITS,
  parameter int RETRIG_CYCLES = 8192
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [NOTE_BITS-1:0]           ev_note,
  input  logic [FREQ_BITS-1:0]           ev_freq,
  output logic [VOICES*FREQ_BITS-1:0]    freq_out,
  output logic [VOICES-1:0]              gate_out,
  output logic [VOICES*NOTE_BITS-1:0]    voice_note,
  output logic                           steal
);

  import rocket_pkg::*;

  localparam int IDX_BITS = $clog2(VOICES);
  localparam int CNT_BITS = $clog2(RETRIG_CYCLES + 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(VOICES - 1);

  alloc_state_t state;

  logic                 ev_on_r;
  logic [NOTE_BITS-1:0] ev_note_r;
  logic [FREQ_BITS-1:0] ev_freq_r;

  logic [IDX_BITS-1:0]  scan_idx;
  logic                 match_found;
  logic [IDX_BITS-1:0]  match_idx;
  logic                 free_found;
  logic [IDX_BITS-1:0]  free_idx;
  logic [IDX_BITS-1:0]  free_rank;

  logic [IDX_BITS-1:0]  retrig_idx;
  logic [CNT_BITS-1:0]  retrig_cnt;

  logic [FREQ_BITS-1:0] freq_r [VOICES];
  logic [NOTE_BITS-1:0] note_r [VOICES];
  logic [VOICES-1:0]    gate_r;

  logic [IDX_BITS-1:0]  rank [VOICES];
  logic [IDX_BITS-1:0]  oldest;

  logic [IDX_BITS-1:0]  tgt;
  logic                 tgt_gated;
  logic                 tgt_steal;
  logic                 touch;

  voice_lru #(
    .VOICES   (VOICES),
    .RANK_BITS(IDX_BITS)
  ) u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .touch    (touch),
    .touch_idx(tgt),
    .rank     (rank),
    .oldest   (oldest)
  );

  assign touch = (state == ST_COMMIT) && ev_on_r;

  // Note-on target choice from the scan results: retrigger, else free, else steal the oldest
  always_comb begin
    tgt       = oldest;
    tgt_gated = 1'b1;
    tgt_steal = 1'b1;
    if (match_found) begin
      tgt       = match_idx;
      tgt_gated = 1'b1;
      tgt_steal = 1'b0;
    end else if (free_found) begin
      tgt       = free_idx;
      tgt_gated = 1'b0;
      tgt_steal = 1'b0;
    end
  end

  // Allocator FSM with the scan registers and the voice register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ev_ready    <= 1'b1;
      steal       <= 1'b0;
      ev_on_r     <= 1'b0;
      ev_note_r   <= '0;
      ev_freq_r   <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      free_rank   <= '0;
      retrig_idx  <= '0;
      retrig_cnt  <= '0;
      gate_r      <= '0;
      for (int i = 0; i < VOICES; i++) begin
        freq_r[i] <= '0;
        note_r[i] <= '0;
      end
    end else begin
      steal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_valid && ev_ready) begin
            ev_on_r     <= ev_on;
            ev_note_r   <= ev_note;
            ev_freq_r   <= ev_freq;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            free_rank   <= '0;
            ev_ready    <= 1'b0;
            state       <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!match_found && gate_r[scan_idx] && (note_r[scan_idx] == ev_note_r)) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!gate_r[scan_idx] && (!free_found || (rank[scan_idx] > free_rank))) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
            free_rank  <= rank[scan_idx];
          end
          if (scan_idx == LAST_IDX) begin
            state <= ST_COMMIT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end

        ST_COMMIT: begin
          if (ev_on_r) begin
            freq_r[tgt] <= ev_freq_r;
            note_r[tgt] <= ev_note_r;
            if (tgt_gated) begin
              gate_r[tgt] <= 1'b0;
              retrig_idx  <= tgt;
              retrig_cnt  <= CNT_BITS'(RETRIG_CYCLES);
              steal       <= tgt_steal;
              state       <= ST_RETRIG;
            end else begin
              gate_r[tgt] <= 1'b1;
              ev_ready    <= 1'b1;
              state       <= ST_IDLE;
            end
          end else begin
            if (match_found) begin
              gate_r[match_idx] <= 1'b0;
            end
            ev_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_RETRIG: begin
          if ((retrig_cnt == CNT_BITS'(1)) || (retrig_cnt == '0)) begin
            gate_r[retrig_idx] <= 1'b1;
            retrig_cnt         <= '0;
            ev_ready           <= 1'b1;
            state              <= ST_IDLE;
          end else begin
            retrig_cnt <= retrig_cnt - 1'b1;
          end
        end

        default: begin
          ev_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign freq_out[g*FREQ_BITS +: FREQ_BITS]   = freq_r[g];
    assign voice_note[g*NOTE_BITS +: NOTE_BITS] = note_r[g];
  end

  assign gate_out = gate_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator. Each event pushes its hand-computed
// expected outcome into a scoreboard queue; a monitor tracks the busy window
// of every accepted event and checks the outputs when ev_ready returns.
module tb_voice_allocator;
  import rocket_pkg::*;

  localparam int V  = VOICES_DEFAULT;
  localparam int R  = 24;
  localparam int FW = V * FREQ_BITS;
  localparam int NW = V * NOTE_BITS;

  typedef struct {
    string         name;
    logic [V-1:0]  gate;
    logic [FW-1:0] freq;
    logic [NW-1:0] note;
    int            busy;
    int            dip;
    int            steals;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ev_valid;
  logic                 ev_ready;
  logic                 ev_on;
  logic [NOTE_BITS-1:0] ev_note;
  logic [FREQ_BITS-1:0] ev_freq;
  logic [FW-1:0]        freq_out;
  logic [V-1:0]         gate_out;
  logic [NW-1:0]        voice_note;
  logic                 steal;

  exp_t sb[$];

  logic [V-1:0]         exp_gate;
  logic [FREQ_BITS-1:0] exp_freq [V];
  logic [NOTE_BITS-1:0] exp_note [V];

  int check_cnt = 0;
  int pass_cnt  = 0;

  bit           in_flight = 1'b0;
  int           mon_busy;
  int           mon_dip;
  int           mon_steals;
  logic [V-1:0] pre_gate;

  voice_allocator #(
    .VOICES       (V),
    .FREQ_BITS    (FREQ_BITS),
    .NOTE_BITS    (NOTE_BITS),
    .RETRIG_CYCLES(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_on     (ev_on),
    .ev_note   (ev_note),
    .ev_freq   (ev_freq),
    .freq_out  (freq_out),
    .gate_out  (gate_out),
    .voice_note(voice_note),
    .steal     (steal)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] pack_freq();
    logic [FW-1:0] r;
    for (int i = 0; i < V; i++) r[i*FREQ_BITS +: FREQ_BITS] = exp_freq[i];
    return r;
  endfunction

  function automatic logic [NW-1:0] pack_note();
    logic [NW-1:0] r;
    for (int i = 0; i < V; i++) r[i*NOTE_BITS +: NOTE_BITS] = exp_note[i];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
    check_cnt++;
    if (got === want) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic apply_stimulus(input bit on, input logic [NOTE_BITS-1:0] note,
                                input logic [FREQ_BITS-1:0] freq, input int busy,
                                input int dip, input int steals, input bit track,
                                input string name);
    exp_t e;
    int   waited;
    if (track) begin
      e.name   = name;
      e.gate   = exp_gate;
      e.freq   = pack_freq();
      e.note   = pack_note();
      e.busy   = busy;
      e.dip    = dip;
      e.steals = steals;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_freq  = freq;
    waited   = 0;
    @(negedge clk);
    while (!ev_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ev_ready) begin
      check_cnt++;
      $display("[TB] FAIL %s_accept: ev_ready got 0, expected 1 within 200 cycles", name);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  // Monitor: measures each accepted event's busy window and checks it when ev_ready returns
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      in_flight = 1'b0;
    end else begin
      if (in_flight) begin
        if (ev_ready) begin
          in_flight = 1'b0;
          if (sb.size() == 0) begin
            check_cnt++;
            $display("[TB] FAIL unexpected_completion: got completion, expected none");
          end else begin
            e = sb.pop_front();
            check_output({e.name, "_gate"},   128'(gate_out),   128'(e.gate));
            check_output({e.name, "_freq"},   128'(freq_out),   128'(e.freq));
            check_output({e.name, "_note"},   128'(voice_note), 128'(e.note));
            check_output({e.name, "_busy"},   128'(mon_busy),   128'(e.busy));
            check_output({e.name, "_gatelow"}, 128'(mon_dip),   128'(e.dip));
            check_output({e.name, "_steal"},  128'(mon_steals), 128'(e.steals));
          end
        end else begin
          mon_busy++;
          if (gate_out !== pre_gate) mon_dip++;
          if (steal) mon_steals++;
        end
      end
      if (!in_flight && ev_valid && ev_ready) begin
        in_flight  = 1'b1;
        mon_busy   = 0;
        mon_dip    = 0;
        mon_steals = 0;
        pre_gate   = gate_out;
      end
    end
  end

  initial begin
    int waited;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    ev_freq  = '0;
    exp_gate = '0;
    for (int i = 0; i < V; i++) begin
      exp_freq[i] = '0;
      exp_note[i] = '0;
    end

    // reset state
    #12;
    check_output("reset_ready", 128'(ev_ready),   128'(1));
    check_output("reset_gate",  128'(gate_out),   128'(0));
    check_output("reset_freq",  128'(freq_out),   128'(0));
    check_output("reset_note",  128'(voice_note), 128'(0));
    check_output("reset_steal", 128'(steal),      128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // first note lands on voice 0 (LRU after reset)
    exp_gate = 4'b0001; exp_freq[0] = 32'h0000_1000; exp_note[0] = 7'd60;
    apply_stimulus(1'b1, 7'd60, 32'h0000_1000, V+1, 0, 0, 1'b1, "on60");

    // fill the remaining voices in LRU order
    exp_gate = 4'b0011; exp_freq[1] = 32'h0000_1100; exp_note[1] = 7'd62;
    apply_stimulus(1'b1, 7'd62, 32'h0000_1100, V+1, 0, 0, 1'b1, "on62");
    exp_gate = 4'b0111; exp_freq[2] = 32'h0000_1200; exp_note[2] = 7'd64;
    apply_stimulus(1'b1, 7'd64, 32'h0000_1200, V+1, 0, 0, 1'b1, "on64");
    exp_gate = 4'b1111; exp_freq[3] = 32'h0000_1300; exp_note[3] = 7'd65;
    apply_stimulus(1'b1, 7'd65, 32'h0000_1300, V+1, 0, 0, 1'b1, "on65");

    // all busy: steal voice 0, gate low for exactly R cycles, one steal pulse
    exp_freq[0] = 32'h0000_1400; exp_note[0] = 7'd67;
    apply_stimulus(1'b1, 7'd67, 32'h0000_1400, V+1+R, R, 1, 1'b1, "steal67");

    // release keeps the pitch
    exp_gate = 4'b1101;
    apply_stimulus(1'b0, 7'd62, 32'h0, V+1, 0, 0, 1'b1, "off62");

    // released voice is reused without stealing
    exp_gate = 4'b1111; exp_freq[1] = 32'h0000_1500; exp_note[1] = 7'd69;
    apply_stimulus(1'b1, 7'd69, 32'h0000_1500, V+1, 0, 0, 1'b1, "on69");

    // held note retriggers in place with the new frequency
    exp_freq[2] = 32'h0000_2200;
    apply_stimulus(1'b1, 7'd64, 32'h0000_2200, V+1+R, R, 0, 1'b1, "retrig64");

    // unheld note-off changes nothing but still takes V+1 cycles
    apply_stimulus(1'b0, 7'd99, 32'h0, V+1, 0, 0, 1'b1, "off99");

    // two free voices: the higher-ranked (voice 3) wins over voice 0
    exp_gate = 4'b0111;
    apply_stimulus(1'b0, 7'd65, 32'h0, V+1, 0, 0, 1'b1, "off65");
    exp_gate = 4'b0110;
    apply_stimulus(1'b0, 7'd67, 32'h0, V+1, 0, 0, 1'b1, "off67");
    exp_gate = 4'b1110; exp_freq[3] = 32'h0000_2700; exp_note[3] = 7'd70;
    apply_stimulus(1'b1, 7'd70, 32'h0000_2700, V+1, 0, 0, 1'b1, "on70");
    exp_gate = 4'b1111; exp_freq[0] = 32'h0000_2900; exp_note[0] = 7'd72;
    apply_stimulus(1'b1, 7'd72, 32'h0000_2900, V+1, 0, 0, 1'b1, "on72");

    // oldest is now voice 1
    exp_freq[1] = 32'h0000_3000; exp_note[1] = 7'd74;
    apply_stimulus(1'b1, 7'd74, 32'h0000_3000, V+1+R, R, 1, 1'b1, "steal74");

    // steal voice 2, then reset in the middle of its retrigger hold
    apply_stimulus(1'b1, 7'd76, 32'h0000_3100, 0, 0, 0, 1'b0, "steal76");
    repeat (10) @(posedge clk);
    #3;
    check_output("midretrig_gate", 128'(gate_out), 128'(4'b1011));
    rst_n = 1'b0;
    #1;
    check_output("async_reset_gate",  128'(gate_out),   128'(0));
    check_output("async_reset_freq",  128'(freq_out),   128'(0));
    check_output("async_reset_note",  128'(voice_note), 128'(0));
    check_output("async_reset_ready", 128'(ev_ready),   128'(1));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // after reset the allocator starts over from voice 0
    exp_gate = 4'b0001;
    for (int i = 0; i < V; i++) begin
      exp_freq[i] = '0;
      exp_note[i] = '0;
    end
    exp_freq[0] = 32'h0000_4000; exp_note[0] = 7'd80;
    apply_stimulus(1'b1, 7'd80, 32'h0000_4000, V+1, 0, 0, 1'b1, "post_reset80");

    waited = 0;
    while ((sb.size() != 0 || in_flight) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL drain: got %0d pending events, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
